// File: rtl/ram_fifo_ctrl.sv
// Pointer and handshake controller that wraps a simple dual-port RAM
// with registered read data into a first-word-fall-through FIFO.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [ADDR_W-1:0] ram_writeAddr,
  output logic [ADDR_W-1:0] ram_readAddr,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              ram_we,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic          out_valid_q;
  logic          out_valid_d;

  logic [PW-1:0] ram_cnt;
  logic          ram_full;
  logic          push;
  logic          pop;
  logic          fetch;

  // ram_cnt uses registered pointers, so a fetch never targets
  // the slot being written in the same cycle.
  always_comb begin
    ram_cnt  = wr_ptr_q - rd_ptr_q;
    ram_full = (ram_cnt == DEPTH);
    push     = in_valid & ~ram_full & ~reset;
    pop      = out_valid_q & out_ready;
    fetch    = (ram_cnt != '0) & (~out_valid_q | out_ready)
             & ~reset;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (fetch) begin
      rd_ptr_d    = rd_ptr_q + ONE;
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Status is forced to its idle view while reset is held.
  always_comb begin
    full      = ram_full & ~reset;
    in_ready  = ~full;
    overflow  = in_valid & full;
    out_valid = out_valid_q & ~reset;
    if (reset) begin
      count = '0;
    end else begin
      count = ram_cnt + {{ADDR_W{1'b0}}, out_valid_q};
    end
    empty = (count == '0);
  end

  always_comb begin
    out_data      = ram_dataOut;
    ram_dataIn    = in_data;
    ram_we        = push;
    ram_en        = fetch;
    ram_writeAddr = wr_ptr_q[ADDR_W-1:0];
    ram_readAddr  = rd_ptr_q[ADDR_W-1:0];
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Random and directed stimulus for ram_fifo_ctrl against a
// queue-based FIFO reference model with a behavioural RAM.
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] ram_writeAddr;
  logic [7:0] ram_readAddr;
  logic [7:0] ram_dataIn;
  logic       ram_we;
  logic       ram_en;
  logic [7:0] ram_dataOut;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .ram_writeAddr(ram_writeAddr),
    .ram_readAddr (ram_readAddr),
    .ram_dataIn   (ram_dataIn),
    .ram_we       (ram_we),
    .ram_en       (ram_en),
    .ram_dataOut  (ram_dataOut)
  );

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (ram_en) ram_dataOut <= mem[ram_readAddr];
    if (ram_we) mem[ram_writeAddr] <= ram_dataIn;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  bit         m_ov;
  logic [7:0] m_od;
  int         m_wcnt;
  int         m_rcnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] id,
                      input logic ordy, input logic rst);
    bit mfull;
    bit ps;
    bit pp;
    bit fe;
    int cnt;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_en", ram_en, 0);
      mq.delete();
      m_ov   = 0;
      m_wcnt = 0;
      m_rcnt = 0;
    end else begin
      mfull = (mq.size() == 256);
      ps    = iv && !mfull;
      pp    = m_ov && ordy;
      fe    = (mq.size() != 0) && (!m_ov || ordy);
      cnt   = mq.size() + int'(m_ov);
      chk("in_ready", in_ready, !mfull);
      chk("full", full, mfull);
      chk("empty", empty, cnt == 0);
      chk("count", count, cnt);
      chk("overflow", overflow, iv && mfull);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) chk("out_data", out_data, m_od);
      chk("ram_we", ram_we, ps);
      chk("ram_en", ram_en, fe);
      if (ps) begin
        chk("wr_addr", ram_writeAddr, m_wcnt % 256);
        chk("wr_data", ram_dataIn, id);
      end
      if (fe) chk("rd_addr", ram_readAddr, m_rcnt % 256);
      if (fe) begin
        m_od = mq.pop_front();
        m_ov = 1;
        m_rcnt++;
      end else if (pp) begin
        m_ov = 0;
      end
      if (ps) begin
        mq.push_back(id);
        m_wcnt++;
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_ov      = 0;
    m_od      = '0;
    m_wcnt    = 0;
    m_rcnt    = 0;

    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    idle(3, 0);
    idle(5, 1);

    for (int i = 0; i < 10; i++) step(1, 8'(i), 1, 0);
    idle(4, 1);

    for (int i = 0; i < 258; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'hAA, 0, 0);
    step(1, 8'hAA, 0, 0);
    step(0, 8'h00, 1, 0);
    idle(3, 0);
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 1, 0);
    idle(270, 1);

    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
    idle(3, 0);
    step(1, 8'h77, 1, 1);
    step(1, 8'h5A, 0, 0);
    step(1, 8'hA5, 0, 0);
    step(1, 8'hC3, 0, 0);
    idle(3, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    idle(4, 1);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(99) < 60), 8'($urandom),
           ($urandom_range(99) < 50),
           ($urandom_range(399) == 0));
    end
    idle(300, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
